// File: rtl/signed_seq_divider.sv
// Sequential signed divider: restoring radix-2 division on operand magnitudes,
// one quotient bit per cycle, with sign fix-up and exception overrides.
module signed_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_dvd;
    logic             r_sign_dvs;
    logic             r_dbz;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_overflow;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_neg;

    // An unsigned WIDTH-bit magnitude covers -2^(WIDTH-1) without an extra bit.
    assign w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

    // Partial remainder stays below 2^(WIDTH-1), so its top bit is never shifted out.
    assign w_shift = {r_rem[WIDTH-2:0], r_acc[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {1'b0, r_dvs};
    assign w_neg   = w_diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_acc         <= '0;
            r_rem         <= '0;
            r_dvs         <= '0;
            r_sign_dvd    <= 1'b0;
            r_sign_dvs    <= 1'b0;
            r_dbz         <= 1'b0;
            r_ovf         <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_acc         <= w_dvd_mag;
                        r_dvs         <= w_dvs_mag;
                        r_rem         <= '0;
                        r_sign_dvd    <= dividend[WIDTH-1];
                        r_sign_dvs    <= divisor[WIDTH-1];
                        r_dbz         <= (divisor == '0);
                        r_ovf         <= (dividend == MIN_VAL) && (divisor == '1);
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_count       <= '0;
                        r_in_ready    <= 1'b0;
                        r_state       <= ITER;
                    end
                end
                ITER: begin
                    r_acc   <= {r_acc[WIDTH-2:0], ~w_neg};
                    r_rem   <= w_neg ? w_shift : w_diff[WIDTH-1:0];
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    // Remainder with a zero divisor is the untouched dividend, so no override needed.
                    if (r_dbz) begin
                        r_quotient <= '1;
                    end else if (r_ovf) begin
                        r_quotient <= MIN_VAL;
                    end else begin
                        r_quotient <= (r_sign_dvd ^ r_sign_dvs) ? -r_acc : r_acc;
                    end
                    r_remainder   <= r_sign_dvd ? -r_rem : r_rem;
                    r_div_by_zero <= r_dbz;
                    r_overflow    <= r_ovf;
                    r_state       <= DONE;
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed and randomized checks of the 8-bit sequential signed divider:
// reset, arithmetic, exceptions, latency, backpressure, abort and back-to-back use.
module tb_signed_seq_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = 8'h00;
    logic [7:0] divisor = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int testsRun = 0;
    int testsFailed = 0;

    signed_seq_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Presents one operand pair, waits (bounded) for the result and hands it back.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [17:0] res, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h3C;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = {quotient, remainder, div_by_zero, overflow};
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        testsRun++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_handshake: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        testsRun++;
        if ({quotient, remainder} !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got %h expected 0000", {quotient, remainder});
        end
        testsRun++;
        if ({div_by_zero, overflow} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: got %b expected 00", {div_by_zero, overflow});
        end
        rst = 1'b0;
        @(negedge clk);
        testsRun++;
        if (in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_arith();
        logic [7:0]  va[14] = '{8'h64, 8'h9C, 8'h64, 8'hAA, 8'h05, 8'h80, 8'h80,
                                8'h7F, 8'h80, 8'h00, 8'h81, 8'hF9, 8'h80, 8'h7F};
        logic [7:0]  vb[14] = '{8'h07, 8'h07, 8'hF9, 8'h55, 8'h00, 8'hFF, 8'h01,
                                8'h80, 8'h80, 8'h05, 8'h02, 8'h00, 8'h00, 8'hFF};
        logic [17:0] ve[14] = '{{8'h0E, 8'h02, 2'b00}, {8'hF2, 8'hFE, 2'b00},
                                {8'hF2, 8'h02, 2'b00}, {8'hFF, 8'hFF, 2'b00},
                                {8'hFF, 8'h05, 2'b10}, {8'h80, 8'h00, 2'b01},
                                {8'h80, 8'h00, 2'b00}, {8'h00, 8'h7F, 2'b00},
                                {8'h01, 8'h00, 2'b00}, {8'h00, 8'h00, 2'b00},
                                {8'hC1, 8'hFF, 2'b00}, {8'hFF, 8'hF9, 2'b10},
                                {8'hFF, 8'h80, 2'b10}, {8'h81, 8'h00, 2'b00}};
        logic [17:0] res;
        int lat;
        for (int i = 0; i < 14; i++) begin
            do_op(va[i], vb[i], res, lat);
            testsRun++;
            if (res !== ve[i]) begin
                testsFailed++;
                $display("[TB] FAIL arith_%0d (%h/%h): got q,r,dz,ov=%h,%h,%b%b expected %h,%h,%b%b",
                         i, va[i], vb[i], res[17:10], res[9:2], res[1], res[0],
                         ve[i][17:10], ve[i][9:2], ve[i][1], ve[i][0]);
            end
            testsRun++;
            if (lat !== 10) begin
                testsFailed++;
                $display("[TB] FAIL latency_%0d: got %0d edges expected 10", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int waitCycles;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'h64;
        divisor  = 8'h07;
        @(posedge clk);
        @(negedge clk);
        // Keep a second request pending while busy; it must not be captured.
        dividend = 8'h10;
        divisor  = 8'h02;
        testsRun++;
        if (in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL busy_ready: got %b expected 0", in_ready);
        end
        waitCycles = 0;
        while (!out_valid && waitCycles < 40) begin
            @(posedge clk);
            waitCycles++;
            @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            testsRun++;
            if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow} !== {2'b10, 8'h0E, 8'h02, 2'b00}) begin
                testsFailed++;
                $display("[TB] FAIL hold_%0d: got v,rdy,q,r=%b,%b,%h,%h expected 1,0,0e,02",
                         c, out_valid, in_ready, quotient, remainder);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        testsRun++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_abort();
        int highs;
        logic [17:0] res;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'h9C;
        divisor  = 8'h07;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        testsRun++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_state: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        highs = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) highs++;
        end
        testsRun++;
        if (highs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL abort_no_valid: got %0d valid cycles expected 0", highs);
        end
        do_op(8'h64, 8'h07, res, lat);
        testsRun++;
        if (res !== {8'h0E, 8'h02, 2'b00} || lat !== 10) begin
            testsFailed++;
            $display("[TB] FAIL after_abort: got %h lat %0d expected %h lat 10", res, lat, {8'h0E, 8'h02, 2'b00});
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] res;
        int lat;
        do_op(8'h80, 8'hFF, res, lat);
        testsRun++;
        if (res !== {8'h80, 8'h00, 2'b01}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first: got %h expected %h", res, {8'h80, 8'h00, 2'b01});
        end
        do_op(8'h64, 8'hF9, res, lat);
        testsRun++;
        if (res !== {8'hF2, 8'h02, 2'b00}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second_flags_cleared: got %h expected %h", res, {8'hF2, 8'h02, 2'b00});
        end
    endtask

    task automatic test_random_sweep();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [17:0] res;
        logic [17:0] exp;
        int lat;
        int sa;
        int sb;
        int q;
        int r;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sb == 0) begin
                exp = {8'hFF, a, 2'b10};
            end else if (sa == -128 && sb == -1) begin
                exp = {8'h80, 8'h00, 2'b01};
            end else begin
                q = sa / sb;
                r = sa % sb;
                exp = {q[7:0], r[7:0], 2'b00};
            end
            do_op(a, b, res, lat);
            testsRun++;
            if (res !== exp || lat !== 10) begin
                testsFailed++;
                $display("[TB] FAIL sweep_%0d (%h/%h): got %h lat %0d expected %h lat 10", i, a, b, res, lat, exp);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_arith();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
